// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR cells with run-time S&R resolution, optional
// rising-edge qualification, sticky conflict flags and a masked interrupt.

module sr_ff_lane #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s,
  input  logic       r,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       clr,
  input  logic       conflict_clr,
  output logic       q,
  output logic       qbar,
  output logic       conflict
);
  logic q_nxt;
  logic hit;

  assign hit = en & s & r & ~clr;

  always_comb begin
    q_nxt = q;
    if (clr) begin
      q_nxt = RST_BIT;
    end else if (en) begin
      case ({s, r})
        2'b10:   q_nxt = 1'b1;
        2'b01:   q_nxt = 1'b0;
        2'b11: begin
          case (mode)
            2'd0:    q_nxt = 1'b1;
            2'd1:    q_nxt = 1'b0;
            2'd2:    q_nxt = q;
            default: q_nxt = ~q;
          endcase
        end
        default: q_nxt = q;
      endcase
    end
  end

  // qbar is its own flop loaded with ~q_nxt so it never matches q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= RST_BIT;
      qbar     <= ~RST_BIT;
      conflict <= 1'b0;
    end else begin
      q    <= q_nxt;
      qbar <= ~q_nxt;
      if (hit)               conflict <= 1'b1;
      else if (conflict_clr) conflict <= 1'b0;
    end
  end
endmodule

module sr_ff_bank #(
  parameter int               WIDTH     = 4,
  parameter int               EDGE_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] en,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic [WIDTH-1:0] conflict_clr,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict,
  output logic             irq
);
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] r_eff;

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [WIDTH-1:0] s_d;
      logic [WIDTH-1:0] r_d;
      // history tracks raw inputs every clock, independent of en/clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_d <= '0;
          r_d <= '0;
        end else begin
          s_d <= s;
          r_d <= r;
        end
      end
      assign s_eff = s & ~s_d;
      assign r_eff = r & ~r_d;
    end else begin : g_lvl
      assign s_eff = s;
      assign r_eff = r;
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sr_ff_lane #(.RST_BIT(RESET_VAL[i])) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .s           (s_eff[i]),
      .r           (r_eff[i]),
      .en          (en[i]),
      .mode        (mode),
      .clr         (clr),
      .conflict_clr(conflict_clr[i]),
      .q           (q[i]),
      .qbar        (qbar[i]),
      .conflict    (conflict[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |(q & irq_mask);
  end
endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: level-mode bank, edge-mode bank and a
// single-bit instance driven from the same stimulus.

module tb_sr_ff_bank;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] s, r, en, conflict_clr, irq_mask;
  logic [1:0] mode;
  logic       clr;

  logic [3:0] q0, qbar0, conflict0;
  logic       irq0;
  logic [3:0] q1, qbar1, conflict1;
  logic       irq1;
  logic [0:0] q2, qbar2, conflict2;
  logic       irq2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(4), .EDGE_MODE(0), .RESET_VAL(4'b0101)) u_lvl (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .mode(mode), .clr(clr),
    .conflict_clr(conflict_clr), .irq_mask(irq_mask),
    .q(q0), .qbar(qbar0), .conflict(conflict0), .irq(irq0)
  );

  sr_ff_bank #(.WIDTH(4), .EDGE_MODE(1), .RESET_VAL(4'b0000)) u_edge (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .mode(mode), .clr(clr),
    .conflict_clr(conflict_clr), .irq_mask(irq_mask),
    .q(q1), .qbar(qbar1), .conflict(conflict1), .irq(irq1)
  );

  sr_ff_bank #(.WIDTH(1)) u_one (
    .clk(clk), .rst_n(rst_n), .s(s[0]), .r(r[0]), .en(en[0]), .mode(mode),
    .clr(clr), .conflict_clr(conflict_clr[0]), .irq_mask(irq_mask[0]),
    .q(q2), .qbar(qbar2), .conflict(conflict2), .irq(irq2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b1; s = '0; r = '0; en = '0; mode = 2'd0; clr = 1'b0;
    conflict_clr = '0; irq_mask = '0;

    // mid-cycle asynchronous reset
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_q",        q0,        32'h5);
    chk("rst_qbar",     qbar0,     32'ha);
    chk("rst_conflict", conflict0, 32'h0);
    chk("rst_irq",      irq0,      32'h0);
    chk("rst_q_edge",   q1,        32'h0);
    chk("rst_qbar_one", qbar2,     32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    chk("en0_hold", q0, 32'h5);

    // basic SR
    en = 4'b1111; s = 4'b0011; r = 4'b1100;
    tick();
    chk("sr_q",    q0,    32'h3);
    chk("sr_qbar", qbar0, 32'hc);
    s = '0; r = '0;
    tick(5);
    chk("sr_hold", q0, 32'h3);

    // conflict resolution modes on channel 0, starting from q[0]=0
    en = 4'b0001; r = 4'b0001;
    tick();
    chk("pre_q0", q0, 32'h2);
    s = 4'b0001; r = 4'b0001; mode = 2'd0;
    tick();
    chk("m0_q",        q0,        32'h3);
    chk("m0_conflict", conflict0, 32'h1);
    chk("one_setdom",  q2,        32'h1);
    chk("one_qbar",    qbar2,     32'h0);
    mode = 2'd1;
    tick();
    chk("m1_q", q0, 32'h2);
    mode = 2'd2;
    tick();
    chk("m2_q", q0, 32'h2);
    mode = 2'd3;
    tick();
    chk("m3_q", q0, 32'h3);
    conflict_clr = 4'b0001;
    tick();
    chk("m3_toggle_back",  q0,        32'h2);
    chk("set_beats_clear", conflict0, 32'h1);
    s = '0; r = '0;
    tick();
    chk("conflict_cleared", conflict0, 32'h0);
    conflict_clr = '0; mode = 2'd0;

    // clr and enable masking
    en = 4'b1111; s = 4'b1111;
    tick();
    chk("all_set", q0, 32'hf);
    clr = 1'b1; r = 4'b1111;
    tick();
    chk("clr_q",          q0,        32'h5);
    chk("clr_qbar",       qbar0,     32'ha);
    chk("clr_noconflict", conflict0, 32'h0);
    clr = 1'b0; s = '0;
    tick();
    chk("all_reset", q0, 32'h0);
    en = 4'b1010; s = 4'b1111; r = '0;
    tick();
    chk("en_mask_q", q0, 32'ha);

    // irq latency and mask change
    irq_mask = 4'b1000; en = 4'b1111; s = '0; r = 4'b1111;
    tick();
    chk("irq_from_old_q", irq0, 32'h1);
    r = '0;
    tick();
    chk("irq_low", irq0, 32'h0);
    en = 4'b1000; s = 4'b1000;
    tick();
    chk("irq_N",   q0,   32'h8);
    chk("irq_N_0", irq0, 32'h0);
    s = '0;
    tick();
    chk("irq_N1", irq0, 32'h1);
    tick();
    chk("irq_N2", irq0, 32'h1);
    irq_mask = 4'b0000;
    tick();
    chk("irq_N3", irq0, 32'h0);

    // edge-qualified inputs, from a fresh reset
    s = '0; r = '0; en = '0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    en = 4'b0100; s = 4'b0100;
    tick();
    chk("edge_first_set", q1, 32'h4);
    tick(9);
    chk("edge_held", q1, 32'h4);
    r = 4'b0100;
    tick();
    chk("edge_r_clears",  q1,        32'h0);
    chk("edge_noconflict", conflict1, 32'h0);
    chk("lvl_conflict",    conflict0, 32'h4);
    r = '0;
    tick(3);
    chk("edge_no_new_set", q1, 32'h0);
    s = '0;
    tick();
    s = 4'b0100;
    tick();
    chk("edge_reraise", q1, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
